// File: rtl/convolucion_secuenciador.sv
// rtl/convolucion_secuenciador.sv - 5x5 mask-convolution controller: config, window admission, token tracking, reduce/clamp, frame count
module convolucion_secuenciador #(
    parameter int BITS_ELEMENTO_MASCARA = 10,
    parameter int BITS_PIXEL            = 8,
    parameter int BITS_PRODUCTO_SUMA    = 11,
    parameter int LATENCIA_MAC          = 2,
    parameter int NUM_PIXELES           = 307200,
    parameter int BITS_CONTADOR         = 19
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_start,
    input  logic                                  cfg_wr_en,
    input  logic [4:0]                            cfg_addr,
    input  logic [BITS_ELEMENTO_MASCARA-1:0]      cfg_data,
    output logic                                  cfg_error,
    output logic [25*BITS_ELEMENTO_MASCARA-1:0]   mask_bus,
    output logic [BITS_ELEMENTO_MASCARA-1:0]      denominador,
    input  logic                                  win_valid,
    output logic                                  win_ready,
    output logic                                  dp_ena,
    input  logic [9*BITS_PRODUCTO_SUMA-1:0]       dp_sumas,
    output logic [BITS_PIXEL-1:0]                 pix_out,
    output logic                                  pix_valid,
    output logic                                  frame_done,
    output logic                                  busy
);

    localparam int BITS_SUMA = BITS_PRODUCTO_SUMA + 4;
    localparam logic [BITS_SUMA-1:0]     PIX_MAX = BITS_SUMA'((1 << BITS_PIXEL) - 1);
    localparam logic [BITS_CONTADOR-1:0] ULTIMO  = BITS_CONTADOR'(NUM_PIXELES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} estado_t;

    estado_t                           estado;
    logic [25:0]                       mapa;
    logic [LATENCIA_MAC-1:0]           tokens;
    logic [LATENCIA_MAC:0]             tokens_sig;
    logic                              cap_valid;
    logic [9*BITS_PRODUCTO_SUMA-1:0]   cap_sumas;
    logic [BITS_CONTADOR-1:0]          contador;
    logic                              acepta;
    logic signed [BITS_SUMA-1:0]       suma;
    logic [BITS_PIXEL-1:0]             pix_nxt;

    assign win_ready  = (estado == RUN);
    assign acepta     = win_valid & win_ready;
    assign dp_ena     = acepta | (|tokens);
    assign tokens_sig = {tokens, acepta};
    assign busy       = (estado == LOAD) || (estado == DRAIN) || (|tokens) || cap_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado      <= IDLE;
            mapa        <= '0;
            cfg_error   <= 1'b0;
            mask_bus    <= '0;
            denominador <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (cfg_start) begin
                        estado    <= LOAD;
                        mapa      <= '0;
                        cfg_error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        mapa      <= '0;
                        cfg_error <= 1'b0;
                    end else begin
                        if (cfg_wr_en) begin
                            if (cfg_addr < 5'd25) begin
                                mask_bus[cfg_addr*BITS_ELEMENTO_MASCARA +: BITS_ELEMENTO_MASCARA] <= cfg_data;
                                mapa[cfg_addr] <= 1'b1;
                            end else if (cfg_addr == 5'd25) begin
                                // A zero denominator is kept but never counts towards a complete map
                                denominador <= cfg_data;
                                mapa[25]    <= (cfg_data != '0);
                                if (cfg_data == '0)
                                    cfg_error <= 1'b1;
                            end else begin
                                cfg_error <= 1'b1;
                            end
                        end
                        if (&mapa)
                            estado <= RUN;
                    end
                end
                RUN: begin
                    if (cfg_start) begin
                        estado    <= DRAIN;
                        cfg_error <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (tokens == '0 && !cap_valid) begin
                        estado    <= LOAD;
                        mapa      <= '0;
                        cfg_error <= 1'b0;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

    always_comb begin
        suma = '0;
        for (int i = 0; i < 9; i++)
            suma = suma + BITS_SUMA'($signed(cap_sumas[i*BITS_PRODUCTO_SUMA +: BITS_PRODUCTO_SUMA]));
    end

    always_comb begin
        pix_nxt = suma[BITS_PIXEL-1:0];
        if (suma[BITS_SUMA-1])
            pix_nxt = '0;
        else if (suma > $signed(PIX_MAX))
            pix_nxt = '1;
    end

    // Tokens only move under dp_ena, which is forced high while any token is inside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tokens     <= '0;
            cap_valid  <= 1'b0;
            cap_sumas  <= '0;
            pix_valid  <= 1'b0;
            pix_out    <= '0;
            frame_done <= 1'b0;
            contador   <= '0;
        end else begin
            if (dp_ena)
                tokens <= tokens_sig[LATENCIA_MAC-1:0];
            cap_valid <= tokens[LATENCIA_MAC-1];
            if (tokens[LATENCIA_MAC-1])
                cap_sumas <= dp_sumas;
            pix_valid  <= cap_valid;
            frame_done <= 1'b0;
            if (cap_valid) begin
                pix_out <= pix_nxt;
                if (contador == ULTIMO) begin
                    contador   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    contador <= contador + 1'b1;
                end
            end
        end
    end

endmodule
